mem_arbiter2: RTL and testbench
===============================

Name: mem_arbiter2

Overview:
- Two-master arbiter sharing the single-port synchronous data/instruction RAM.
- Master 0 is the riscvmulti core's memory port, wrapped in a req/gnt shim. Master 1 is a DMA/debug loader.
- Arbitration is round-robin. A master asserting lock may keep up to MAX_HOLD consecutive grants while the other master waits.
- Read data is returned one cycle after grant, tagged to the granted master.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byte mask width = DATA_W/8)
MAX_HOLD, 4, max consecutive grants to a locking master while the other requests (>=1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
m0_req  in  1  master 0 access request
m0_we  in  1  master 0 write (1) / read (0)
m0_lock  in  1  master 0 requests to keep ownership
m0_addr  in  ADDR_W  master 0 address
m0_wdata  in  DATA_W  master 0 write data
m0_wmask  in  DATA_W/8  master 0 byte write mask
m0_gnt  out  1  master 0 request accepted this cycle
m0_rvalid  out  1  master 0 read data valid
m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_wmask  in  same as m0_*  master 1 request
m1_gnt, m1_rvalid  out  1  master 1 grant and read valid
rdata  out  DATA_W  read data, common to both masters, qualified by mX_rvalid
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_we  out  1  RAM write enable
mem_wmask  out  DATA_W/8  RAM byte mask
mem_rdata  in  DATA_W  RAM read data, valid the cycle after the address is presented

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, last_grant=1 (so master 0 wins the first tie), hold_cnt=0, rvalid_q=0.
  - m0_rvalid=m1_rvalid=0.
  - gnt outputs follow the combinational rules below, but are forced 0 while reset=0.
- State register: IDLE (no grant last cycle), OWN0, OWN1 (grant to that master last cycle). last_grant persists through IDLE for round-robin.
- Grant decision is combinational, in the same cycle as req:
  - Only one req high: grant that master.
  - Both high, owner = last_grant:
    - owner's lock=1 and hold_cnt<MAX_HOLD: grant owner.
    - otherwise: grant the other master.
  - Neither high: no grant.
- At most one gnt per cycle. gnt never asserts without the matching req.
- Granted cycle drives the granted master's addr/wdata/wmask/we onto mem_*.
- No-grant cycle: mem_we=0, mem_wmask=0, mem_addr=m0_addr, mem_wdata=m0_wdata.
- Masters hold req and payload stable until gnt. The same master may be granted on consecutive cycles (full throughput).
- Read response:
  - A read granted in cycle N gives mX_rvalid=1 in cycle N+1 for that master only, with rdata=mem_rdata.
  - Writes never produce rvalid.
  - A response in N+1 coexists with a new grant in N+1 to either master.
- hold_cnt, updated on the clock edge:
  - Grant to the same master as last_grant: hold_cnt<=min(hold_cnt+1, MAX_HOLD).
  - Grant to the other master: hold_cnt<=1, last_grant flips.
  - No grant: hold_cnt<=0, last_grant unchanged.
- Transitions:
  - Any state -> OWN0 / OWN1 on grant to m0 / m1.
  - Any state -> IDLE on no grant.
- Lock drop: the other master's pending req wins at the next tie.
- Lock with no competing req: unlimited grants. hold_cnt saturates at MAX_HOLD.
- Reset mid-operation: a pending rvalid is discarded (outputs 0 immediately). The counter and RR state return to reset values.

Test Plan:
- Reset release, m0_req read addr 0x10, mem_rdata=0xDEADBEEF next cycle -> m0_gnt same cycle, mem_addr=0x10, mem_we=0; m0_rvalid=1, rdata=0xDEADBEEF one cycle later; m1_rvalid stays 0.
- Both req from reset, no lock, held for 4 cycles -> grant sequence m0,m1,m0,m1.
- m1 write addr 0x20, wdata 0x000000AA, wmask 0001 -> m1_gnt, mem_we=1, mem_wmask=0001, mem_addr=0x20; no rvalid follows.
- Both req, m0_lock=1 held, MAX_HOLD=4 -> m0 granted 4 consecutive cycles, then m1 on cycle 5, then m0 again.
- m0 read granted in cycle N, m1 read granted in N+1 -> m0_rvalid in N+1, m1_rvalid in N+2, never both high in one cycle.
- reset=0 asserted the cycle after a read grant -> m0_rvalid=0 immediately; after release, a tie grants m0 first.

Source files
------------

// File: rtl/mem_arbiter2.sv
// Two-master round-robin arbiter in front of a single-port synchronous RAM.
// A locking master may keep up to MAX_HOLD back-to-back grants while the other master waits.
module mem_arbiter2 #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                m0_req,
    input  logic                m0_we,
    input  logic                m0_lock,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wmask,
    output logic                m0_gnt,
    output logic                m0_rvalid,
    input  logic                m1_req,
    input  logic                m1_we,
    input  logic                m1_lock,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wmask,
    output logic                m1_gnt,
    output logic                m1_rvalid,
    output logic [DATA_W-1:0]   rdata,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int                HOLD_W   = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              read_q, read_d;
    logic              gnt0, gnt1;
    logic              owner_keeps;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            hold_cnt_q   <= '0;
            read_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            hold_cnt_q   <= hold_cnt_d;
            read_q       <= read_d;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        owner_keeps  = 1'b0;
        last_grant_d = last_grant_q;
        hold_cnt_d   = '0;

        if (reset) begin
            if (m0_req && m1_req) begin
                owner_keeps = (last_grant_q ? m1_lock : m0_lock) && (hold_cnt_q < HOLD_MAX);
                gnt1        = last_grant_q ? owner_keeps : !owner_keeps;
                gnt0        = !gnt1;
            end else begin
                gnt0 = m0_req;
                gnt1 = m1_req;
            end
        end

        if (gnt0 || gnt1) begin
            if (gnt1 == last_grant_q) begin
                hold_cnt_d = (hold_cnt_q < HOLD_MAX) ? hold_cnt_q + 1'b1 : HOLD_MAX;
            end else begin
                hold_cnt_d   = HOLD_W'(1);
                last_grant_d = gnt1;
            end
        end

        if (gnt0)      state_d = OWN0;
        else if (gnt1) state_d = OWN1;
        else           state_d = IDLE;

        read_d = (gnt0 && !m0_we) || (gnt1 && !m1_we);
    end

    // The response is steered by who owned the RAM in the previous cycle.
    always_comb begin
        m0_gnt    = gnt0;
        m1_gnt    = gnt1;
        m0_rvalid = read_q && (state_q == OWN0);
        m1_rvalid = read_q && (state_q == OWN1);
        rdata     = mem_rdata;
        if (gnt1) begin
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_we    = m1_we;
            mem_wmask = m1_wmask;
        end else begin
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            mem_we    = gnt0 && m0_we;
            mem_wmask = gnt0 ? m0_wmask : '0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter2.sv
// Bench for mem_arbiter2: directed scenarios plus random traffic against a
// transaction-level model of the arbitration rules and a scoreboard memory.
module tb_mem_arbiter2;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;
    localparam int MH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req, we, lock;
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];
    logic [MW-1:0] wmask [2];
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [MW-1:0] mem_wmask;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_arbiter2 #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (req[0]),
        .m0_we     (we[0]),
        .m0_lock   (lock[0]),
        .m0_addr   (addr[0]),
        .m0_wdata  (wdata[0]),
        .m0_wmask  (wmask[0]),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m1_req    (req[1]),
        .m1_we     (we[1]),
        .m1_lock   (lock[1]),
        .m1_addr   (addr[1]),
        .m1_wdata  (wdata[1]),
        .m1_wmask  (wmask[1]),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_wmask (mem_wmask),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [DW-1:0] init_word(input int i);
        return (i == 4) ? 32'hDEAD_BEEF : 32'h1000_0000 + i * 32'h0101_0101;
    endfunction

    // Behavioural synchronous RAM, 16 words, re-initialised while reset is low.
    logic [DW-1:0] ram [16];
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) ram[i] <= init_word(i);
        end else if (mem_we) begin
            for (int b = 0; b < MW; b++)
                if (mem_wmask[b]) ram[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        mem_rdata <= ram[mem_addr[5:2]];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    int            m_last = 1;
    int            m_hold = 0;
    bit [1:0]      m_rv   = '0;
    logic [DW-1:0] m_rdata;
    logic [DW-1:0] mmem [16];
    int            m_g = -1;
    int            gnt_log[$];

    // Inputs are set at a negedge; check 1 ns later, advance model, move to next negedge.
    task automatic cycle();
        int            g, own, obs, idx;
        bit            lk;
        logic          e_we;
        logic [MW-1:0] e_mask;
        #1;
        if (!reset) begin
            m_last = 1;
            m_hold = 0;
            m_rv   = '0;
            for (int i = 0; i < 16; i++) mmem[i] = init_word(i);
        end
        g = -1;
        if (reset) begin
            if (req == 2'b01)      g = 0;
            else if (req == 2'b10) g = 1;
            else if (req == 2'b11) begin
                own = m_last;
                lk  = lock[own];
                g   = (lk && m_hold < MH) ? own : 1 - own;
            end
        end
        e_we   = 1'b0;
        e_mask = '0;
        if (g >= 0) begin
            e_we   = we[g];
            e_mask = wmask[g];
        end
        check("m0_gnt", m0_gnt, g == 0);
        check("m1_gnt", m1_gnt, g == 1);
        check("mem_we", mem_we, e_we);
        check("mem_wmask", mem_wmask, e_mask);
        check("mem_addr", mem_addr, (g == 1) ? addr[1] : addr[0]);
        check("mem_wdata", mem_wdata, (g == 1) ? wdata[1] : wdata[0]);
        check("m0_rvalid", m0_rvalid, m_rv[0]);
        check("m1_rvalid", m1_rvalid, m_rv[1]);
        if (m_rv != 0) check("rdata", rdata, m_rdata);
        obs = m0_gnt ? 0 : (m1_gnt ? 1 : -1);
        gnt_log.push_back(obs);

        m_rv = '0;
        if (g >= 0) begin
            if (g == m_last) begin
                m_hold = (m_hold < MH) ? m_hold + 1 : MH;
            end else begin
                m_hold = 1;
                m_last = g;
            end
            idx = int'(addr[g][5:2]);
            if (we[g]) begin
                for (int b = 0; b < MW; b++)
                    if (wmask[g][b]) mmem[idx][8*b +: 8] = wdata[g][8*b +: 8];
            end else begin
                m_rv[g] = 1'b1;
                m_rdata = mmem[idx];
            end
        end else begin
            m_hold = 0;
        end
        m_g = g;
        @(negedge clk);
    endtask

    task automatic set_m(input int i, input logic r, input logic w, input logic l,
                         input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
        req[i]   = r;
        we[i]    = w;
        lock[i]  = l;
        addr[i]  = a;
        wdata[i] = d;
        wmask[i] = m;
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        req   = '0;
        cycle();
        reset = 1'b1;
    endtask

    task automatic rand_master(input int i);
        set_m(i, $urandom_range(0, 99) < 70, 1'($urandom), $urandom_range(0, 3) == 0,
              {26'b0, 4'($urandom_range(0, 15)), 2'b00}, $urandom, 4'($urandom));
    endtask

    initial begin
        int exp_alt [4] = '{0, 1, 0, 1};
        int exp_lock[6] = '{0, 0, 0, 0, 1, 0};

        reset = 1'b0;
        set_m(0, 1'b1, 1'b0, 1'b0, 32'h10, '0, '0);
        set_m(1, 1'b1, 1'b0, 1'b0, 32'h14, '0, '0);
        @(negedge clk);
        repeat (2) cycle();

        // Single read of 0x10 right after reset release.
        reset = 1'b1;
        set_m(1, 1'b0, 1'b0, 1'b0, 32'h14, '0, '0);
        cycle();
        check("t1_gnt", gnt_log[$], 0);
        req = '0;
        check("t1_rvalid", m0_rvalid, 1'b1);
        check("t1_rdata", rdata, 32'hDEAD_BEEF);
        check("t1_m1_rvalid", m1_rvalid, 1'b0);
        cycle();

        // Round-robin tie from reset.
        reset_pulse();
        set_m(0, 1'b1, 1'b0, 1'b0, 32'h4, '0, '0);
        set_m(1, 1'b1, 1'b0, 1'b0, 32'h8, '0, '0);
        gnt_log.delete();
        repeat (4) cycle();
        for (int k = 0; k < 4; k++) check("alt_seq", gnt_log[k], exp_alt[k]);

        // Masked write from master 1.
        req = '0;
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0000_00AA, 4'b0001);
        cycle();
        req = '0;
        check("wr_no_rvalid", m1_rvalid, 1'b0);
        set_m(1, 1'b1, 1'b0, 1'b0, 32'h20, '0, '0);
        cycle();
        req = '0;
        check("wr_readback", rdata, {init_word(8)[31:8], 8'hAA});
        cycle();

        // Lock held by master 0 against a waiting master 1.
        reset_pulse();
        set_m(0, 1'b1, 1'b0, 1'b1, 32'h4, '0, '0);
        set_m(1, 1'b1, 1'b0, 1'b0, 32'h8, '0, '0);
        gnt_log.delete();
        repeat (6) cycle();
        for (int k = 0; k < 6; k++) check("lock_seq", gnt_log[k], exp_lock[k]);

        // Back-to-back reads from different masters.
        req = '0;
        lock = '0;
        set_m(0, 1'b1, 1'b0, 1'b0, 32'h10, '0, '0);
        cycle();
        req = 2'b10;
        check("b2b_m0_rv", m0_rvalid, 1'b1);
        check("b2b_m1_rv0", m1_rvalid, 1'b0);
        cycle();
        req = '0;
        check("b2b_m1_rv", m1_rvalid, 1'b1);
        check("b2b_m0_rv0", m0_rvalid, 1'b0);
        cycle();

        // Reset asserted right after a read grant.
        req = 2'b01;
        cycle();
        reset = 1'b0;
        #1 check("rst_rvalid", m0_rvalid, 1'b0);
        cycle();
        reset = 1'b1;
        req = 2'b11;
        cycle();
        check("rst_tie_m0", gnt_log[$], 0);

        // Random traffic; a master keeps its request stable until granted.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!req[i] || m_g == i) rand_master(i);
                else lock[i] = $urandom_range(0, 3) != 0;
            end
            reset = ($urandom_range(0, 199) != 0);
            cycle();
        end
        reset = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
